// File: rtl/mul_div_unit.sv
// Iterative MIPS32 multiply/divide unit with HI/LO registers.
// Radix-2 shift-add multiply and restoring divide over WIDTH cycles, with sign fix-up at the end.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;
  // Multiplicand for multiply, divisor for divide.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    a_orig_d   = a_orig_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    mag_a      = (op[0] && A[WIDTH-1]) ? neg_w(A) : A;
    mag_b      = (op[0] && B[WIDTH-1]) ? neg_w(B) : B;
    mul_sum    = {(WIDTH+1){1'b0}};
    div_shift  = {(WIDTH+1){1'b0}};
    div_diff   = {(WIDTH+2){1'b0}};
    prod       = {(2*WIDTH){1'b0}};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d       = op;
          neg_quo_d  = op[0] & (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_rem_d  = op[0] & A[WIDTH-1];
          a_orig_d   = A;
          div_zero_d = 1'b0;
          rem_d      = {(WIDTH+1){1'b0}};
          if (op[1]) begin
            opnd_d = mag_b;
            acc_d  = {{WIDTH{1'b0}}, mag_a};
          end else begin
            opnd_d = mag_a;
            acc_d  = {{WIDTH{1'b0}}, mag_b};
          end
          if (op[1] && (B == {WIDTH{1'b0}})) begin
            state_d = S_FIX;
          end else begin
            state_d = S_RUN;
            cnt_d   = CNT_INIT;
          end
        end else begin
          if (hi_we) hi_d = wdata;
          else       hi_d = hi_q;
          if (lo_we) lo_d = wdata;
          else       lo_d = lo_q;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_FIX;
        else                  state_d = S_RUN;
        if (op_q[1]) begin
          // Restoring step: keep the trial difference only when it does not borrow.
          div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
          div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
          if (div_diff[WIDTH+1]) rem_d = div_shift;
          else                   rem_d = div_diff[WIDTH:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
        end else begin
          // Add the multiplicand into the upper half when the low multiplier bit is set, then shift right.
          mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
          acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (op_q[1]) begin
          if (opnd_q == {WIDTH{1'b0}}) begin
            lo_d       = {WIDTH{1'b1}};
            hi_d       = a_orig_q;
            div_zero_d = 1'b1;
          end else begin
            lo_d = neg_quo_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
            hi_d = neg_rem_q ? neg_w(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
          end
        end else begin
          prod = neg_quo_q ? neg_2w(acc_q) : acc_q;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 2'b00;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      a_orig_q   <= {WIDTH{1'b0}};
      opnd_q     <= {WIDTH{1'b0}};
      acc_q      <= {(2*WIDTH){1'b0}};
      rem_q      <= {(WIDTH+1){1'b0}};
      cnt_q      <= {CW{1'b0}};
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      a_orig_q   <= a_orig_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;
  logic        m_dz;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {hi,lo} from MIPS semantics using 64-bit integer arithmetic.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] res, output logic dz);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    dz = 1'b0;
    res = 64'd0;
    if (o == 2'b00) res = ua * ub;
    else if (o == 2'b01) res = sa * sb;
    else if (b == 32'd0) begin
      dz = 1'b1;
      res = {a, 32'hFFFFFFFF};
    end else if (o == 2'b10) res = {a % b, a / b};
    else begin
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, input bit wr_with_start);
    logic [63:0] exp;
    logic        exp_dz;
    int          lat, busy_cyc, exp_lat;
    bit          stable;
    model(o, a, b, exp, exp_dz);
    exp_lat = (o[1] && b == 32'd0) ? 2 : 34;
    @(posedge clk); #1;
    start = 1'b1; op = o; A = a; B = b;
    if (wr_with_start) begin
      hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
    end
    @(posedge clk); #1;
    idle_inputs();
    check("accept_busy", busy, 1);
    check("dz_cleared_on_accept", div_zero, 0);
    lat = 1; busy_cyc = 0; stable = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cyc++;
      if (hi !== m_hi || lo !== m_lo) stable = 0;
      if (inject && lat == 5) begin
        start = 1'b1; op = ~o; A = $urandom; B = $urandom;
        hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
      end else idle_inputs();
      @(posedge clk); #1;
      lat++;
    end
    idle_inputs();
    check("latency", lat, exp_lat);
    check("busy_cycles", busy_cyc, exp_lat - 1);
    check("hilo_stable_while_busy", stable, 1);
    check("busy_at_done", busy, 0);
    check("hi", hi, exp[63:32]);
    check("lo", lo, exp[31:0]);
    check("div_zero", div_zero, exp_dz);
    m_hi = exp[63:32]; m_lo = exp[31:0]; m_dz = exp_dz;
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("div_zero_held", div_zero, m_dz);
    check("hi_held", hi, m_hi);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; op = 2'b00; A = 32'd0; B = 32'd0; wdata = 32'd0;
    idle_inputs();
    m_hi = 32'd0; m_lo = 32'd0; m_dz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    reset = 1'b0;

    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    run_op(2'b01, 32'hFFFFFFF9, 32'd3, 0, 0);
    run_op(2'b01, 32'h80000000, 32'h80000000, 0, 0);
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, 0, 0);
    run_op(2'b10, 32'd7, 32'd2, 0, 0);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    run_op(2'b10, 32'd5, 32'd0, 0, 0);
    run_op(2'b11, 32'hFFFFFFF0, 32'd0, 0, 0);
    run_op(2'b00, 32'd10, 32'd10, 1, 0);
    run_op(2'b10, 32'd1000, 32'd7, 0, 1);

    // MTHI alone, then MTHI+MTLO together.
    @(posedge clk); #1;
    hi_we = 1'b1; wdata = 32'h00001234;
    @(posedge clk); #1;
    idle_inputs();
    check("mthi_hi", hi, 32'h00001234);
    check("mthi_lo_kept", lo, m_lo);
    m_hi = 32'h00001234;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    idle_inputs();
    check("mtboth_hi", hi, 32'hCAFEF00D);
    check("mtboth_lo", lo, 32'hCAFEF00D);
    m_hi = 32'hCAFEF00D; m_lo = 32'hCAFEF00D;

    // Reset during the 10th RUN cycle aborts the operation.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; A = 32'hDEADBEEF; B = 32'h12345678;
    @(posedge clk); #1;
    idle_inputs();
    repeat (9) @(posedge clk);
    #1;
    check("run10_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    m_hi = 32'd0; m_lo = 32'd0;
    run_op(2'b00, 32'd3, 32'd4, 0, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       ra = 32'h80000000;
        1:       ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
